latch_write_sequencer: RTL and testbench

- Clocked writer for a bank of level-sensitive enable latches with asynchronous active-low reset.
- Accepts a data word over a valid/ready handshake and drives the latch data and enable lines.
- Sequence: data is set up before enable, enable is held for a programmable pulse, data is held stable after enable falls.
- Sits between synchronous control logic and latch-based storage. Guarantees the latch never sees data change while enable is high.

---
 rtl/latch_write_sequencer.sv | 102 ++++++++++
 tb/tb_latch_write_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/latch_write_sequencer.sv
// ============================================================================
// Module  : latch_write_sequencer
// Purpose : Sequences setup / enable-pulse / hold writes into a latch bank.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module latch_write_sequencer #(
  parameter int WIDTH        = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic             clk_in,
  input  logic             n_rst_in,
  input  logic             wr_valid_in,
  input  logic [WIDTH-1:0] wr_data_in,
  output logic             wr_ready_out,
  output logic             latch_en_out,
  output logic [WIDTH-1:0] latch_d_out,
  output logic             busy_out,
  output logic             done_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] C_SETUP_LOAD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] C_PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] C_HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

  state_t             r_state;
  logic [7:0]         r_count;
  logic               r_en;
  logic [WIDTH-1:0]   r_d;
  logic               r_done;

  // Data only moves on acceptance in IDLE, so it is frozen across every enable window.
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      r_state <= S_IDLE;
      r_count <= 8'd0;
      r_en    <= 1'b0;
      r_d     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_valid_in) begin
            r_d     <= wr_data_in;
            r_count <= C_SETUP_LOAD;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
          end else begin
            r_en    <= 1'b1;
            r_count <= C_PULSE_LOAD;
            r_state <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
          end else begin
            r_en    <= 1'b0;
            r_count <= C_HOLD_LOAD;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_en    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_ready_out = (r_state == S_IDLE);
  assign busy_out     = (r_state != S_IDLE);
  assign latch_en_out = r_en;
  assign latch_d_out  = r_d;
  assign done_out     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_latch_write_sequencer.sv
// ============================================================================
// Module  : tb_latch_write_sequencer
// Purpose : Directed self-checking bench for latch_write_sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_latch_write_sequencer;

  logic       clk_in = 1'b0;
  logic       n_rst_in;
  logic       wr_valid_in;
  logic [7:0] wr_data_in;
  logic       wr_ready_out, latch_en_out, busy_out, done_out;
  logic [7:0] latch_d_out;

  logic       s_rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready, s_en, s_busy, s_done;
  logic [7:0] s_d;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_in = ~clk_in;

  latch_write_sequencer u_dut (
    .clk_in       (clk_in),
    .n_rst_in     (n_rst_in),
    .wr_valid_in  (wr_valid_in),
    .wr_data_in   (wr_data_in),
    .wr_ready_out (wr_ready_out),
    .latch_en_out (latch_en_out),
    .latch_d_out  (latch_d_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  latch_write_sequencer #(
    .WIDTH(8), .SETUP_CYCLES(3), .PULSE_CYCLES(1), .HOLD_CYCLES(4)
  ) u_sweep (
    .clk_in       (clk_in),
    .n_rst_in     (s_rst_n),
    .wr_valid_in  (s_valid),
    .wr_data_in   (s_data),
    .wr_ready_out (s_ready),
    .latch_en_out (s_en),
    .latch_d_out  (s_d),
    .busy_out     (s_busy),
    .done_out     (s_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; sample and drive 1 time unit later.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    n_rst_in = 1'b0; wr_valid_in = 1'b0; wr_data_in = 8'h00;
    s_rst_n  = 1'b0; s_valid     = 1'b0; s_data     = 8'h00;
    #1;
    chk("rst_ready", wr_ready_out, 1);
    chk("rst_en",    latch_en_out, 0);
    chk("rst_d",     latch_d_out,  8'h00);
    chk("rst_done",  done_out,     0);
    chk("rst_busy",  busy_out,     0);
    tick(); tick();
    n_rst_in = 1'b1; s_rst_n = 1'b1;
    tick();

    // Single write with default timing
    wr_valid_in = 1'b1; wr_data_in = 8'hA5;
    tick();
    wr_valid_in = 1'b0;
    chk("t1_e0_d",     latch_d_out,  8'hA5);
    chk("t1_e0_en",    latch_en_out, 0);
    chk("t1_e0_busy",  busy_out,     1);
    chk("t1_e0_ready", wr_ready_out, 0);
    tick(); chk("t1_e1_en", latch_en_out, 1);
    tick(); chk("t1_e2_en", latch_en_out, 1);
    tick(); chk("t1_e3_en", latch_en_out, 0); chk("t1_e3_done", done_out, 0);
    tick(); chk("t1_e4_done", done_out, 1); chk("t1_e4_ready", wr_ready_out, 1);
    chk("t1_e4_busy", busy_out, 0);
    tick(); chk("t1_e5_done", done_out, 0);

    // Back-to-back writes with valid held high
    wr_valid_in = 1'b1; wr_data_in = 8'h11;
    tick(); chk("t2_e0_d", latch_d_out, 8'h11);
    wr_data_in = 8'h22;
    tick(); chk("t2_e1_en", latch_en_out, 1); chk("t2_e1_d", latch_d_out, 8'h11);
    tick(); chk("t2_e2_en", latch_en_out, 1); chk("t2_e2_d", latch_d_out, 8'h11);
    tick(); chk("t2_e3_en", latch_en_out, 0); chk("t2_e3_d", latch_d_out, 8'h11);
    tick(); chk("t2_e4_done", done_out, 1); chk("t2_e4_d", latch_d_out, 8'h11);
    tick(); chk("t2_e5_d", latch_d_out, 8'h22); chk("t2_e5_busy", busy_out, 1);
    chk("t2_e5_done", done_out, 0);
    wr_valid_in = 1'b0;
    tick(); chk("t2_e6_en", latch_en_out, 1);
    tick(); tick();
    tick(); chk("t2_e9_done", done_out, 1);
    tick();

    // Requests during PULSE are ignored
    wr_valid_in = 1'b1; wr_data_in = 8'h3C;
    tick(); wr_valid_in = 1'b0;
    tick(); chk("t3_e1_en", latch_en_out, 1);
    wr_valid_in = 1'b1; wr_data_in = 8'hFF;
    chk("t3_ready_busy", wr_ready_out, 0);
    tick(); chk("t3_e2_d", latch_d_out, 8'h3C); chk("t3_e2_done", done_out, 0);
    tick(); chk("t3_e3_d", latch_d_out, 8'h3C); chk("t3_e3_done", done_out, 0);
    tick(); chk("t3_e4_done", done_out, 1);
    wr_valid_in = 1'b0;
    tick(); chk("t3_e5_done", done_out, 0); chk("t3_e5_d", latch_d_out, 8'h3C);
    tick(); chk("t3_e6_done", done_out, 0);

    // Asynchronous reset while enable is high
    wr_valid_in = 1'b1; wr_data_in = 8'h77;
    tick(); wr_valid_in = 1'b0;
    tick(); chk("t4_pre_en", latch_en_out, 1);
    #2 n_rst_in = 1'b0;
    #1;
    chk("t4_rst_en",    latch_en_out, 0);
    chk("t4_rst_d",     latch_d_out,  8'h00);
    chk("t4_rst_ready", wr_ready_out, 1);
    chk("t4_rst_done",  done_out,     0);
    tick(); chk("t4_hold_done", done_out, 0);
    n_rst_in = 1'b1;
    tick(); chk("t4_post_done", done_out, 0);
    tick(); chk("t4_post2_done", done_out, 0);
    wr_valid_in = 1'b1; wr_data_in = 8'h5A;
    tick(); wr_valid_in = 1'b0;
    chk("t4_new_d", latch_d_out, 8'h5A);
    tick(); chk("t4_new_en", latch_en_out, 1);
    tick(); tick();
    tick(); chk("t4_new_done", done_out, 1); chk("t4_new_d2", latch_d_out, 8'h5A);
    tick();

    // Idle hold after a write of 0x42
    wr_valid_in = 1'b1; wr_data_in = 8'h42;
    tick(); wr_valid_in = 1'b0; wr_data_in = 8'h99;
    tick(); tick(); tick();
    tick(); chk("t6_done", done_out, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_idle", {latch_d_out, latch_en_out, done_out}, {8'h42, 1'b0, 1'b0});
    end

    // Sweep instance: SETUP=3, PULSE=1, HOLD=4
    s_valid = 1'b1; s_data = 8'h81;
    tick(); s_valid = 1'b0;
    chk("t5_e0_d", s_d, 8'h81);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t5_en",    s_en,    (k == 3) ? 1 : 0);
      chk("t5_ready", s_ready, (k == 8) ? 1 : 0);
      chk("t5_done",  s_done,  (k == 8) ? 1 : 0);
    end
    tick(); chk("t5_after_done", s_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
